// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline stage with optional 2-entry skid buffer
// out_data always comes from the main entry; the skid entry only buffers while downstream stalls.
module pipe_stage_reg #(
   parameter int DATA_W = 112,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   state_t state, state_n;
   logic [DATA_W-1:0] skid_data;
   logic in_fire, out_fire, load_in, load_skid, skid_to_main;
   always_comb begin
      out_valid    = state != EMPTY;
      in_ready     = (SKID != 0) ? state != TWO : !out_valid | out_ready;
      in_fire      = in_valid & in_ready;
      out_fire     = out_valid & out_ready;
      occupancy    = state;
      state_n      = state;
      load_in      = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (flush)
         state_n = EMPTY;
      else
         case (state)
            EMPTY: if (in_fire) begin
               load_in = 1'b1;
               state_n = ONE;
            end
            ONE: if (in_fire & !out_fire & (SKID != 0)) begin
               load_skid = 1'b1;
               state_n   = TWO;
            end else if (in_fire)
               load_in = 1'b1;
            else if (out_fire)
               state_n = EMPTY;
            TWO: if (out_fire) begin
               skid_to_main = 1'b1;
               state_n      = ONE;
            end
            default: state_n = EMPTY;
         endcase
   end
   always_ff @(posedge clock)
      state <= reset ? EMPTY : state_n;
   // Payload registers are not cleared by flush; out_valid qualifies them.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_data  <= '0;
         skid_data <= '0;
      end else begin
         if (load_in)
            out_data <= in_data;
         else if (skid_to_main)
            out_data <= skid_data;
         if (load_skid)
            skid_data <= in_data;
      end
   end
   always_ff @(posedge clock) begin
      if (reset)
         stall_cnt <= '0;
      else if (out_valid & !out_ready & (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives skid, non-skid and 4-bit-counter stages against a FIFO reference model
module tb_pipe_stage_reg;
   logic clock = 1'b0;
   logic reset, flush, in_valid, out_ready;
   logic [111:0] in_data;
   logic ir[3], ov[3];
   logic [111:0] od[3];
   logic [1:0] occ[3];
   logic [15:0] sc0, sc1;
   logic [3:0] sc2;
   int total = 0, bad = 0;
   int m_cnt[3];
   int m_stall[3];
   logic [111:0] m_d[3][2];
   int m_skid[3] = '{1, 0, 1};
   int m_max[3] = '{65535, 65535, 15};

   always #5 clock = ~clock;

   pipe_stage_reg #(.DATA_W(112), .SKID(1), .CNT_W(16)) u_skid (
      .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
      .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
      .occupancy(occ[0]), .stall_cnt(sc0));
   pipe_stage_reg #(.DATA_W(112), .SKID(0), .CNT_W(16)) u_noskid (
      .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
      .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
      .occupancy(occ[1]), .stall_cnt(sc1));
   pipe_stage_reg #(.DATA_W(112), .SKID(1), .CNT_W(4)) u_sat (
      .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
      .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
      .occupancy(occ[2]), .stall_cnt(sc2));

   function automatic logic [15:0] sc(input int i);
      return i == 0 ? sc0 : i == 1 ? sc1 : {12'd0, sc2};
   endfunction

   function automatic logic model_ready(input int i);
      return m_skid[i] != 0 ? m_cnt[i] < 2 : (m_cnt[i] == 0 || out_ready);
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic rs, input logic fl, input logic iv, input logic [111:0] d,
                      input logic ordy);
      logic mr[3];
      reset = rs; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
      #1;
      for (int i = 0; i < 3; i++) begin
         mr[i] = model_ready(i);
         if (!rs) chk($sformatf("in_ready%0d", i), 128'(ir[i]), 128'(mr[i]));
      end
      @(posedge clock);
      for (int i = 0; i < 3; i++) begin
         if (rs) begin
            m_cnt[i] = 0;
            m_stall[i] = 0;
         end else begin
            if (m_cnt[i] > 0 && !ordy && m_stall[i] < m_max[i]) m_stall[i]++;
            if (fl) m_cnt[i] = 0;
            else begin
               if (m_cnt[i] > 0 && ordy) begin
                  m_d[i][0] = m_d[i][1];
                  m_cnt[i]--;
               end
               if (iv && mr[i]) begin
                  m_d[i][m_cnt[i]] = d;
                  m_cnt[i]++;
               end
            end
         end
      end
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("out_valid%0d", i), 128'(ov[i]), 128'(m_cnt[i] > 0));
         chk($sformatf("occupancy%0d", i), 128'(occ[i]), 128'(m_cnt[i]));
         chk($sformatf("stall_cnt%0d", i), 128'(sc(i)), 128'(m_stall[i]));
         if (m_cnt[i] > 0) chk($sformatf("out_data%0d", i), 128'(od[i]), 128'(m_d[i][0]));
      end
      @(negedge clock);
   endtask

   initial begin
      logic [127:0] t;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_stall[i] = 0; end
      @(negedge clock);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) chk($sformatf("rst_data%0d", i), 128'(od[i]), 128'd0);
      // streaming at full throughput
      cyc(0, 0, 1, 112'h1, 1); chk("stream1", 128'(od[0]), 128'h1);
      cyc(0, 0, 1, 112'h2, 1); chk("stream2", 128'(od[0]), 128'h2);
      cyc(0, 0, 1, 112'h3, 1); chk("stream3", 128'(od[0]), 128'h3);
      chk("stream_stall", 128'(sc0), 128'd0);
      cyc(0, 0, 0, 0, 1);
      // backpressure fills the skid entry, then drains in order
      cyc(0, 0, 1, 112'hA, 0); chk("bp_occ1", 128'(occ[0]), 128'd1);
      chk("ns_ready_low", 128'(ir[1]), 128'd0);
      cyc(0, 0, 1, 112'hB, 0); chk("bp_occ2", 128'(occ[0]), 128'd2);
      chk("bp_ready", 128'(ir[0]), 128'd0); chk("bp_hold", 128'(od[0]), 128'hA);
      cyc(0, 0, 1, 112'hC, 0); chk("bp_hold2", 128'(od[0]), 128'hA);
      cyc(0, 0, 1, 112'hC, 1); chk("drain_b", 128'(od[0]), 128'hB);
      cyc(0, 0, 1, 112'hC, 1); chk("drain_c", 128'(od[0]), 128'hC);
      cyc(0, 0, 0, 0, 1);
      // flush while full drops the simultaneous input
      cyc(0, 0, 1, 112'h11, 0);
      cyc(0, 0, 1, 112'h12, 0);
      cyc(0, 1, 1, 112'hD, 0);
      chk("fl_valid", 128'(ov[0]), 128'd0); chk("fl_ready", 128'(ir[0]), 128'd1);
      cyc(0, 0, 0, 0, 1); chk("fl_empty", 128'(ov[0]), 128'd0);
      // reset while full
      cyc(0, 0, 1, 112'h21, 0);
      cyc(0, 0, 1, 112'h22, 0);
      cyc(1, 0, 0, 0, 0);
      chk("mid_rst_data", 128'(od[0]), 128'd0); chk("mid_rst_stall", 128'(sc0), 128'd0);
      chk("mid_rst_occ", 128'(occ[0]), 128'd0);
      // seamless replace in the single-entry stage
      cyc(0, 0, 1, 112'h31, 1);
      cyc(0, 0, 1, 112'h32, 1); chk("ns_replace", 128'(od[1]), 128'h32);
      // saturation of the 4-bit counter
      cyc(0, 0, 1, 112'h41, 0);
      repeat (20) cyc(0, 0, 0, 0, 0);
      chk("sat", 128'(sc2), 128'd15);
      // random traffic
      repeat (400) begin
         t = {$urandom(), $urandom(), $urandom(), $urandom()};
         cyc(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 3) != 0), t[111:0], 1'($urandom_range(0, 2) != 0));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
